// File: rtl/prbs21_if.sv
// Serial PRBS bit stream into the checker, plus its lock status and error counters back out.
interface prbs21_if #(
    parameter int unsigned CNT_W = 16
);
    logic             bit_valid;
    logic             bit_in;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] lock_loss_count;

    modport master (
        output bit_valid, bit_in,
        input  locked, err_pulse, err_count, lock_loss_count
    );

    modport slave (
        input  bit_valid, bit_in,
        output locked, err_pulse, err_count, lock_loss_count
    );
endinterface

// File: rtl/prbs21_checker.sv
// Self-synchronising checker for the x^21 + x^19 + 1 PRBS stream (MSB-out generator).
// Predicts each bit from the received history, tracks lock and counts bit errors / lock losses.
module prbs21_checker #(
    parameter int unsigned LFSR_W     = 21,
    parameter int unsigned TAP        = 19,
    parameter int unsigned LOCK_GOOD  = 32,
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    prbs21_if.slave bus
);
    localparam int unsigned SEED_W = $clog2(LFSR_W + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    state_t            state;
    logic [LFSR_W-1:0] hist;
    logic [SEED_W-1:0] seed_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [ERR_W-1:0]  win_err;

    logic              pred_c;
    logic              mismatch_c;
    logic [LFSR_W-1:0] hist_next_c;
    logic [ERR_W-1:0]  win_err_next_c;

    // Prediction uses the history before the incoming bit is shifted in.
    assign pred_c         = hist[LFSR_W-1] ^ hist[TAP-1];
    assign mismatch_c     = bus.bit_in ^ pred_c;
    assign hist_next_c    = {hist[LFSR_W-2:0], bus.bit_in};
    assign win_err_next_c = win_err + ERR_W'(mismatch_c);

    // Note: rst_n is an active-high synchronous reset despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state               <= SEED;
            hist                <= '0;
            seed_cnt            <= '0;
            good_cnt            <= '0;
            win_cnt             <= '0;
            win_err             <= '0;
            bus.locked          <= 1'b0;
            bus.err_pulse       <= 1'b0;
            bus.err_count       <= '0;
            bus.lock_loss_count <= '0;
        end else begin
            bus.err_pulse <= 1'b0;
            if (bus.bit_valid) begin
                hist <= hist_next_c;
            end
            case (state)
                SEED: begin
                    if (bus.bit_valid) begin
                        if (seed_cnt >= SEED_W'(LFSR_W - 1)) begin
                            seed_cnt <= SEED_W'(LFSR_W);
                            if (hist_next_c != '0) begin
                                state    <= VERIFY;
                                good_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + SEED_W'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (bus.bit_valid) begin
                        if (mismatch_c || (hist_next_c == '0)) begin
                            state    <= SEED;
                            seed_cnt <= '0;
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                            win_cnt    <= '0;
                            win_err    <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (bus.bit_valid) begin
                        if (mismatch_c) begin
                            bus.err_pulse <= 1'b1;
                            if (bus.err_count != CNT_MAX) begin
                                bus.err_count <= bus.err_count + CNT_W'(1);
                            end
                        end
                        // An error on the window-closing bit still counts against that window.
                        if (win_err_next_c == ERR_W'(ERR_THRESH)) begin
                            state      <= LOST;
                            bus.locked <= 1'b0;
                            if (bus.lock_loss_count != CNT_MAX) begin
                                bus.lock_loss_count <= bus.lock_loss_count + CNT_W'(1);
                            end
                        end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_next_c;
                        end
                    end
                end
                LOST: begin
                    state    <= SEED;
                    seed_cnt <= '0;
                    good_cnt <= '0;
                    win_cnt  <= '0;
                    win_err  <= '0;
                end
                default: state <= SEED;
            endcase
        end
    end
endmodule

// File: tb/tb_prbs21_checker.sv
// Directed bench for prbs21_checker: generator-driven stream, per-bit expected outputs queued
// from a hand-derived timeline (lock bit, error bits, loss/relock bits) and checked after each edge.
module tb_prbs21_checker;
    localparam int unsigned LFSR_W = 21;
    localparam int unsigned TAP    = 19;
    localparam int          NEVER  = 1 << 30;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] ec;
        logic [15:0] lcc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    prbs21_if #(.CNT_W(16)) bus_a ();
    prbs21_if #(.CNT_W(4))  bus_b ();

    prbs21_checker #(
        .LFSR_W(21), .TAP(19), .LOCK_GOOD(32), .WINDOW(256), .ERR_THRESH(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(bus_a)
    );

    prbs21_checker #(
        .LFSR_W(21), .TAP(19), .LOCK_GOOD(32), .WINDOW(1048576), .ERR_THRESH(64), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b)
    );

    int          tests = 0;
    int          fails = 0;
    obs_t        exp_q[$];
    logic [20:0] gen;
    int          flips[$];
    int          lock_at, loss_at, relock_at, sat_max;
    int          bitn;
    logic        e_locked;
    int          e_ec, e_lcc;

    task automatic gen_bit(output logic b);
        b   = gen[20];
        gen = {gen[19:0], gen[20] ^ gen[18]};
    endtask

    function automatic bit flip_hit(input int n);
        foreach (flips[i]) if (flips[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // A flipped bit f disturbs the prediction at f, f+TAP and f+LFSR_W.
    function automatic bit is_err(input int n);
        foreach (flips[i])
            if (n == flips[i] || n == flips[i] + TAP || n == flips[i] + LFSR_W) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit locked_after(input int n);
        return (n >= lock_at && (loss_at == 0 || n < loss_at)) || (loss_at != 0 && n >= relock_at);
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) o = {bus_a.locked, bus_a.err_pulse, bus_a.err_count, bus_a.lock_loss_count};
        else          o = {bus_b.locked, bus_b.err_pulse, 16'(bus_b.err_count), 16'(bus_b.lock_loss_count)};
        return o;
    endfunction

    task automatic drive(input int sel, input logic v, input logic b);
        bus_a.bit_valid = (sel == 0) ? v : 1'b0;
        bus_a.bit_in    = (sel == 0) ? b : 1'b0;
        bus_b.bit_valid = (sel == 1) ? v : 1'b0;
        bus_b.bit_in    = (sel == 1) ? b : 1'b0;
    endtask

    task automatic check(input int sel, input string tag);
        obs_t got;
        obs_t e;
        got = sample(sel);
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s bit %0d: scoreboard empty, got %h", tag, bitn, got);
        end else begin
            e = exp_q.pop_front();
            assert (got === e) else begin
                fails++;
                $error("FAIL %s bit %0d: got locked=%b pulse=%b ec=%0d lcc=%0d, expected locked=%b pulse=%b ec=%0d lcc=%0d",
                       tag, bitn, got.locked, got.pulse, got.ec, got.lcc, e.locked, e.pulse, e.ec, e.lcc);
            end
        end
    endtask

    task automatic push_exp(input logic l, input logic p);
        obs_t e;
        e.locked = l;
        e.pulse  = p;
        e.ec     = 16'(e_ec);
        e.lcc    = 16'(e_lcc);
        exp_q.push_back(e);
    endtask

    // One valid bit: src 0 = generator (with flips), 1 = stuck 0, 2 = stuck 1.
    task automatic send_bit(input int sel, input int src, input string tag);
        logic b;
        logic p;
        bitn++;
        case (src)
            0:       begin gen_bit(b); if (flip_hit(bitn)) b = ~b; end
            1:       b = 1'b0;
            default: b = 1'b1;
        endcase
        p = e_locked && is_err(bitn);
        if (p && e_ec < sat_max) e_ec++;
        if (loss_at == bitn) e_lcc++;
        e_locked = locked_after(bitn);
        push_exp(e_locked, p);
        drive(sel, 1'b1, b);
        @(posedge clk); #1;
        check(sel, tag);
    endtask

    task automatic idle(input int sel, input string tag);
        push_exp(e_locked, 1'b0);
        drive(sel, 1'b0, 1'($urandom_range(1)));
        @(posedge clk); #1;
        check(sel, tag);
    endtask

    task automatic scenario(input int l, input int lo, input int rl);
        lock_at = l; loss_at = lo; relock_at = rl;
        flips.delete();
    endtask

    // One-cycle reset with a valid bit present: reset must win, every output 0.
    task automatic do_reset(input int sel, input string tag);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        bitn = 0; e_locked = 1'b0; e_ec = 0; e_lcc = 0;
        push_exp(1'b0, 1'b0);
        drive(sel, 1'b1, 1'b1);
        @(posedge clk); #1;
        check(sel, tag);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sat_max = 65535;
        drive(0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // T1: clean stream, lock exactly after bit 53, no errors over 10000 bits
        do_reset(0, "t1_reset");
        gen = 21'h1; scenario(53, 0, 0);
        repeat (10000) send_bit(0, 0, "t1_clean");

        // T2: single flip -> pulses at 1000, 1019, 1021, lock kept
        do_reset(0, "t2_reset");
        gen = 21'h1; scenario(53, 0, 0); flips.push_back(1000);
        repeat (1100) send_bit(0, 0, "t2_flip");

        // T3: flips 1000 and 1050 in one window -> 4th error at 1050 loses lock, relock at 1104
        do_reset(0, "t3_reset");
        gen = 21'h1; scenario(53, 1050, 1104); flips.push_back(1000); flips.push_back(1050);
        repeat (1150) send_bit(0, 0, "t3_loss");

        // 4th error landing on the window-closing bit 309 still forces loss
        do_reset(0, "t3b_reset");
        gen = 21'h1; scenario(53, 309, 363); flips.push_back(100); flips.push_back(309);
        repeat (400) send_bit(0, 0, "t3b_winedge");

        // T4: valid one clk in four, same bit-indexed behaviour, nothing moves on idle clks
        do_reset(0, "t4_reset");
        gen = 21'h1; scenario(53, 0, 0); flips.push_back(100);
        for (int i = 0; i < 200; i++) begin
            send_bit(0, 0, "t4_valid");
            repeat (3) idle(0, "t4_idle");
        end

        // T5: stuck-at streams never lock
        do_reset(0, "t5_reset0");
        scenario(NEVER, 0, 0);
        repeat (5000) send_bit(0, 1, "t5_stuck0");
        do_reset(0, "t5_reset1");
        scenario(NEVER, 0, 0);
        repeat (1000) send_bit(0, 2, "t5_stuck1");

        // T6: reach err_count=5 across two windows, reset mid-lock, relock 53 bits later
        do_reset(0, "t6_reset");
        gen = 21'h1; scenario(53, 0, 0); flips.push_back(100); flips.push_back(555);
        repeat (575) send_bit(0, 0, "t6_errs");
        do_reset(0, "t6_midlock_reset");
        scenario(53, 0, 0);
        repeat (100) send_bit(0, 0, "t6_relock");

        // T6b: narrow counter saturates at 15 after 20 isolated flips (60 errors)
        sat_max = 15;
        do_reset(1, "t6b_reset");
        gen = 21'h1; scenario(53, 0, 0);
        for (int k = 0; k < 20; k++) flips.push_back(100 + 50 * k);
        repeat (1100) send_bit(1, 0, "t6b_sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
